// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 memory responder: word/address types, FSM state
// encoding and the address range helper.
package lc3_pkg;

  typedef logic [15:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } mem_state_e;

  localparam int CNT_W = 4;

  // An address is implemented only if every bit above the RAM index is zero.
  function automatic logic addr_in_range(input addr_t addr, input int addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// Single-port synchronous word RAM with a one-cycle read and no reset.
module lc3_mem_array
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];

  // The read register only updates on an enabled read, so it holds its value
  // for as long as the response is being presented.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/lc3_mem_responder.sv
// Responder for the LC-3 core memory port: one request at a time, WAIT_CYC
// wait states, then a read-data or write-ack response over valid/ready.
module lc3_mem_responder
  import lc3_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  if (WAIT_CYC > 15) begin : g_bad_wait_cyc
    $error("lc3_mem_responder: WAIT_CYC must be in 0..15");
  end

  mem_state_e       state;
  mem_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic  lat_we;
  addr_t lat_addr;
  word_t lat_wdata;
  logic  lat_err;

  logic  ram_en;
  word_t ram_rdata;

  assign accept  = req_valid && req_ready;
  assign lat_err = !addr_in_range(lat_addr, ADDR_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        cnt <= CNT_W'(WAIT_CYC);
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Request payload is captured only on the accept edge; it is not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (accept) state_nxt = (WAIT_CYC == 0) ? ACCESS : WAIT;
      WAIT:   if (cnt == CNT_W'(1)) state_nxt = ACCESS;
      ACCESS: state_nxt = RESP;
      RESP:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range accesses never touch the RAM, so a dropped write cannot alias.
  assign ram_en = (state == ACCESS) && !lat_err;

  lc3_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (lat_we),
    .addr  (lat_addr[ADDR_W-1:0]),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && lat_err;
  assign rsp_rdata = (rsp_valid && !lat_we && !lat_err) ? ram_rdata : 16'h0000;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: instance a uses WAIT_CYC=2,
// instance b uses WAIT_CYC=0 for the back-to-back throughput case.
module tb_lc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [15:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [15:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [15:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [15:0] b_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYC(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT_CYC(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  // Presents a request, waits for the accept edge, then returns at the first
  // negedge where rsp_valid is high. lat = edges after the accept edge, -1 on timeout.
  task automatic issue_a(input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, output int lat);
    int n;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0; a_req_we = 1'bx; a_req_addr = 16'hxxxx; a_req_wdata = 16'hxxxx;
    lat = 0;
    while (!a_rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    if (!a_rsp_valid) lat = -1;
  endtask

  task automatic issue_b(input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, output int lat);
    int n;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    n = 0;
    while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    lat = 0;
    while (!b_rsp_valid && lat < 30) begin @(negedge clk); lat++; end
    if (!b_rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", a_rsp_valid); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
    checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", a_req_ready); end
    checks++; if (a_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata got %h exp 0000", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", a_rsp_err); end
    checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_req_ready got %b exp 1", b_req_ready); end
  endtask

  task automatic test_write_read();
    int lat;
    // Known background values for the range and reset-abandon tests.
    issue_a(1'b1, 16'h0000, 16'h5A5A, lat);
    issue_a(1'b1, 16'h0010, 16'h1111, lat);
    issue_a(1'b1, 16'h0040, 16'hBEEF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", lat); end
    checks++; if (a_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL wr_rdata got %h exp 0000", a_rsp_rdata); end
    checks++; if (a_rsp_err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", a_rsp_err); end
    @(negedge clk);
    checks++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL wr_release got valid=%b ready=%b exp valid=0 ready=1", a_rsp_valid, a_req_ready); end
    issue_a(1'b0, 16'h0040, 16'h0000, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (a_rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_rdata got %h exp BEEF", a_rsp_rdata); end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    a_rsp_ready = 1'b0;
    issue_a(1'b0, 16'h0040, 16'h0000, lat);
    // A competing write is held on the request port while the response stalls.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0040; a_req_wdata = 16'hDEAD;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'hBEEF || a_req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_stable got %0d bad cycles exp 0", bad); end
    checks++; if (a_rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL stall_rdata got %h exp BEEF", a_rsp_rdata); end
    a_rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got ready=%b valid=%b exp ready=1 valid=0", a_req_ready, a_rsp_valid); end
    a_req_valid = 1'b0;
    issue_a(1'b0, 16'h0040, 16'h0000, lat);
    checks++; if (a_rsp_rdata !== 16'hBEEF) begin errors++; $display("FAIL stall_no_accept got %h exp BEEF", a_rsp_rdata); end
  endtask

  task automatic test_range();
    int lat;
    issue_a(1'b1, 16'hFC00, 16'h1234, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL range_latency got %0d exp 3", lat); end
    checks++; if (a_rsp_err !== 1'b1) begin errors++; $display("FAIL range_wr_err got %b exp 1", a_rsp_err); end
    checks++; if (a_rsp_rdata !== 16'h0000) begin errors++; $display("FAIL range_wr_rdata got %h exp 0000", a_rsp_rdata); end
    issue_a(1'b0, 16'h0000, 16'h0000, lat);
    checks++; if (a_rsp_rdata !== 16'h5A5A || a_rsp_err !== 1'b0) begin
      errors++; $display("FAIL range_alias got %h err=%b exp 5A5A err=0", a_rsp_rdata, a_rsp_err); end
    issue_a(1'b0, 16'h0400, 16'h0000, lat);
    checks++; if (a_rsp_err !== 1'b1 || a_rsp_rdata !== 16'h0000) begin
      errors++; $display("FAIL range_rd got %h err=%b exp 0000 err=1", a_rsp_rdata, a_rsp_err); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int issued;
    int nrsp;
    int acc_cyc;
    int rsp_cyc [2];
    logic [15:0] rsp_dat [2];
    logic [15:0] addrs [2];
    issue_b(1'b1, 16'h0001, 16'h0101, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_wr_latency got %0d exp 1", lat); end
    issue_b(1'b1, 16'h0002, 16'h0202, lat);
    @(negedge clk);
    addrs[0] = 16'h0001; addrs[1] = 16'h0002;
    issued = 0; nrsp = 0; acc_cyc = -1;
    b_req_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (b_rsp_valid && nrsp < 2) begin
        rsp_cyc[nrsp] = k; rsp_dat[nrsp] = b_rsp_rdata; nrsp++;
      end
      if (b_req_ready && issued < 2) begin
        b_req_valid = 1'b1; b_req_addr = addrs[issued];
        if (issued == 0) acc_cyc = k;
        issued++;
      end else begin
        b_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (nrsp !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", nrsp); end
    if (nrsp == 2) begin
      checks++; if (rsp_cyc[0] - acc_cyc !== 2) begin
        errors++; $display("FAIL b2b_first_latency got %0d exp 2", rsp_cyc[0] - acc_cyc); end
      checks++; if (rsp_cyc[1] - rsp_cyc[0] !== 3) begin
        errors++; $display("FAIL b2b_spacing got %0d exp 3", rsp_cyc[1] - rsp_cyc[0]); end
      checks++; if (rsp_dat[0] !== 16'h0101) begin errors++; $display("FAIL b2b_data0 got %h exp 0101", rsp_dat[0]); end
      checks++; if (rsp_dat[1] !== 16'h0202) begin errors++; $display("FAIL b2b_data1 got %h exp 0202", rsp_dat[1]); end
    end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    int n;
    int seen;
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 16'h0010; a_req_wdata = 16'hAAAA;
    n = 0;
    while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", a_busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a_busy !== 1'b0 || a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_idle got busy=%b valid=%b ready=%b exp 0 0 1", a_busy, a_rsp_valid, a_req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_rsp_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_rsp got %0d cycles exp 0", seen); end
    issue_a(1'b0, 16'h0010, 16'h0000, lat);
    checks++; if (a_rsp_rdata !== 16'h1111) begin errors++; $display("FAIL mid_old_value got %h exp 1111", a_rsp_rdata); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_range();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
